// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: function, ALU op and branch-condition codes shared by the issue front end.
package alu_issue_pkg;
    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_AND  = 4'd2;
    localparam logic [3:0] FN_OR   = 4'd3;
    localparam logic [3:0] FN_XOR  = 4'd4;
    localparam logic [3:0] FN_XNOR = 4'd5;
    localparam logic [3:0] FN_SLT  = 4'd6;
    localparam logic [3:0] FN_CMP  = 4'd7;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_AND  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_XOR  = 4'd4;
    localparam logic [3:0] ALUOP_XNOR = 4'd5;
    localparam logic [3:0] ALUOP_SLT  = 4'd6;

    localparam logic [1:0] COND_NONE = 2'd0;
    localparam logic [1:0] COND_EQ   = 2'd1;
    localparam logic [1:0] COND_LT   = 2'd2;
    localparam logic [1:0] COND_GT   = 2'd3;
endpackage

// File: rtl/alu_issue_fn_decode.sv
// alu_fn_decode: maps an ISA function code to the ALU op code plus compare/illegal markers.
module alu_fn_decode
    import alu_issue_pkg::*;
(
    input  logic [3:0] fn,
    output logic [3:0] op,
    output logic       is_cmp,
    output logic       illegal
);
    // fn 0-6 share their encoding with the ALU op codes
    assign illegal = fn[3];
    assign is_cmp  = fn == FN_CMP;
    assign op      = illegal ? ALUOP_ADD : is_cmp ? ALUOP_SUB : fn;
endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/retire front end for the ALU with valid/ready on both sides.
// Define ALU_ISSUE_ERR_EN to flag illegal function codes on resp_err.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int W     = 16,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_fn,
    input  logic [1:0]       req_cond,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [W-1:0]     alu_data1,
    output logic [W-1:0]     alu_data2,
    output logic [3:0]       alu_operation,
    input  logic [W-1:0]     alu_result,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_gt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [W-1:0]     resp_result,
    output logic [2:0]       resp_flags,
    output logic             resp_taken,
`ifdef ALU_ISSUE_ERR_EN
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err
`else
    output logic [TAG_W-1:0] resp_tag
`endif
);
`ifdef ALU_ISSUE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic             s1_valid_q, s2_valid_q;
    logic [W-1:0]     a_q, b_q;
    logic [3:0]       op_q;
    logic             cmp_q, ill_q;
    logic [1:0]       cond_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic [W-1:0]     res_q, res_d;
    logic [2:0]       flags_q, flags_d;
    logic             taken_q, taken_d;
    logic [3:0]       dec_op;
    logic             dec_cmp, dec_ill;
    logic             s2_free, adv, acc, bad;

    alu_fn_decode u_dec (.fn(req_fn), .op(dec_op), .is_cmp(dec_cmp), .illegal(dec_ill));

    assign s2_free       = !s2_valid_q || resp_ready;
    assign adv           = s1_valid_q && s2_free;
    assign req_ready     = !s1_valid_q || s2_free;
    assign acc           = req_valid && req_ready;
    assign alu_data1     = a_q;
    assign alu_data2     = b_q;
    assign alu_operation = s1_valid_q ? op_q : ALUOP_ADD;
    assign resp_valid    = s2_valid_q;
    assign resp_result   = res_q;
    assign resp_flags    = flags_q;
    assign resp_taken    = taken_q;
    assign resp_tag      = tag2_q;

    // illegal codes only squash the response when error reporting is built in
    always_comb begin
        bad     = ERR_EN && ill_q;
        res_d   = (cmp_q || bad) ? '0 : alu_result;
        flags_d = bad ? 3'b000 : {alu_gt, alu_lt, alu_zero};
        taken_d = !bad && (cond_q == COND_EQ ? alu_zero :
                           cond_q == COND_LT ? alu_lt :
                           cond_q == COND_GT ? alu_gt : 1'b0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALUOP_ADD;
            cmp_q      <= 1'b0;
            ill_q      <= 1'b0;
            cond_q     <= COND_NONE;
            tag1_q     <= '0;
        end else if (acc) begin
            s1_valid_q <= 1'b1;
            a_q        <= req_a;
            b_q        <= req_b;
            op_q       <= dec_op;
            cmp_q      <= dec_cmp;
            ill_q      <= dec_ill;
            cond_q     <= req_cond;
            tag1_q     <= req_tag;
        end else if (adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            flags_q    <= 3'b000;
            taken_q    <= 1'b0;
            tag2_q     <= '0;
        end else if (adv) begin
            s2_valid_q <= 1'b1;
            res_q      <= res_d;
            flags_q    <= flags_d;
            taken_q    <= taken_d;
            tag2_q     <= tag1_q;
        end else if (s2_free) begin
            s2_valid_q <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_ERR_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if (adv) err_q <= bad;
    end
    assign resp_err = err_q;
`endif
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and random stimulus for alu_issue against a transaction-level queue model.
module tb_alu_issue;
    import alu_issue_pkg::*;
`ifdef ALU_ISSUE_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [3:0]  req_fn = '0;
    logic [1:0]  req_cond = '0;
    logic [15:0] req_a = '0, req_b = '0;
    logic [2:0]  req_tag = '0;
    logic [15:0] alu_data1, alu_data2, alu_result;
    logic [3:0]  alu_operation;
    logic        alu_zero, alu_lt, alu_gt;
    logic        resp_valid, resp_ready = 1'b0;
    logic [15:0] resp_result;
    logic [2:0]  resp_flags;
    logic        resp_taken;
    logic [2:0]  resp_tag;
`ifdef ALU_ISSUE_ERR_EN
    logic        resp_err;
`endif

    typedef struct {
        logic [3:0]  fn;
        logic [1:0]  cond;
        logic [15:0] a, b;
        logic [2:0]  tag;
        int          e;
    } item_t;

    item_t q[$];
    int    e = 0;
    int    total = 0;
    int    bad = 0;

    alu_issue #(.W(16), .TAG_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_fn(req_fn), .req_cond(req_cond),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_operation(alu_operation),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_gt(alu_gt),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_flags(resp_flags), .resp_taken(resp_taken),
`ifdef ALU_ISSUE_ERR_EN
        .resp_tag(resp_tag), .resp_err(resp_err)
`else
        .resp_tag(resp_tag)
`endif
    );

    always #5 clk = ~clk;

    // ALU stand-in: combinational on the DUT's alu_* outputs, unsigned compares of the operands
    always_comb begin
        alu_zero = alu_data1 == alu_data2;
        alu_lt   = alu_data1 <  alu_data2;
        alu_gt   = alu_data1 >  alu_data2;
        case (alu_operation)
            4'd1:    alu_result = alu_data1 - alu_data2;
            4'd2:    alu_result = alu_data1 & alu_data2;
            4'd3:    alu_result = alu_data1 | alu_data2;
            4'd4:    alu_result = alu_data1 ^ alu_data2;
            4'd5:    alu_result = ~(alu_data1 ^ alu_data2);
            4'd6:    alu_result = {15'd0, alu_lt};
            default: alu_result = alu_data1 + alu_data2;
        endcase
    end

    // expected {err, taken, flags, result} straight from the function/condition rules
    function automatic logic [20:0] model(input item_t it);
        logic [15:0] r;
        logic z, l, g, tk, ill;
        z   = it.a == it.b;
        l   = it.a <  it.b;
        g   = it.a >  it.b;
        ill = ERR && (it.fn > 4'd7);
        case (it.fn)
            4'd0:    r = it.a + it.b;
            4'd1:    r = it.a - it.b;
            4'd2:    r = it.a & it.b;
            4'd3:    r = it.a | it.b;
            4'd4:    r = it.a ^ it.b;
            4'd5:    r = ~(it.a ^ it.b);
            4'd6:    r = l ? 16'd1 : 16'd0;
            4'd7:    r = 16'd0;
            default: r = ill ? 16'd0 : it.a + it.b;
        endcase
        case (it.cond)
            2'd1:    tk = z;
            2'd2:    tk = l;
            2'd3:    tk = g;
            default: tk = 1'b0;
        endcase
        if (ill) return {1'b1, 1'b0, 3'b000, 16'd0};
        return {1'b0, tk, g, l, z, r};
    endfunction

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", t, o, x);
        end
    endtask

    task automatic check_now();
        logic [20:0] m;
        logic ev;
        ev = q.size() > 0 && e > q[0].e;
        chk("req_ready", {31'd0, req_ready}, {31'd0, (q.size() < 2) || resp_ready});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, ev});
        if (ev) begin
            m = model(q[0]);
            chk("resp_result", {16'd0, resp_result}, {16'd0, m[15:0]});
            chk("resp_flags", {29'd0, resp_flags}, {29'd0, m[18:16]});
            chk("resp_taken", {31'd0, resp_taken}, {31'd0, m[19]});
            chk("resp_tag", {29'd0, resp_tag}, {29'd0, q[0].tag});
`ifdef ALU_ISSUE_ERR_EN
            chk("resp_err", {31'd0, resp_err}, {31'd0, m[20]});
`endif
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] fn, input logic [1:0] c,
                       input logic [15:0] a, input logic [15:0] b, input logic [2:0] t,
                       input logic rr, output logic acc);
        logic ret;
        req_valid = v; req_fn = fn; req_cond = c; req_a = a; req_b = b; req_tag = t;
        resp_ready = rr;
        #1 check_now();
        acc = v && (q.size() < 2 || rr);
        ret = q.size() > 0 && e > q[0].e && rr;
        @(posedge clk);
        e++;
        if (ret) void'(q.pop_front());
        if (acc) q.push_back('{fn, c, a, b, t, e});
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        logic acc;
        cyc(1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 3'd0, rr, acc);
    endtask

    // accept one request, then hold it in S2 so its fields can be read
    task automatic one(input logic [3:0] fn, input logic [1:0] c, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] t);
        logic acc;
        cyc(1'b1, fn, c, a, b, t, 1'b1, acc);
        chk("one_acc", {31'd0, acc}, 32'd1);
        idle(1'b0);
    endtask

    task automatic zeros(input string t);
        chk({t, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({t, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({t, "_resp_data"}, {9'd0, resp_result, resp_flags, resp_taken, resp_tag}, 32'd0);
        chk({t, "_alu"}, {alu_data1, alu_data2}, 32'd0);
        chk({t, "_aluop"}, {28'd0, alu_operation}, 32'd0);
`ifdef ALU_ISSUE_ERR_EN
        chk({t, "_err"}, {31'd0, resp_err}, 32'd0);
`endif
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && q.size() > 0; k++) idle(1'b1);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        logic acc;
        logic [3:0] pat;
        int sent;
        #1 rst = 1'b1;
        #1 zeros("por");
        @(negedge clk);
        rst = 1'b0;

        one(FN_ADD, COND_NONE, 16'hFFFF, 16'h0001, 3'd5);
        chk("add_res", {16'd0, resp_result}, 32'h0000);
        chk("add_flags", {29'd0, resp_flags}, 32'b100);
        chk("add_tag", {29'd0, resp_tag}, 32'd5);
        one(FN_CMP, COND_EQ, 16'h0010, 16'h0010, 3'd1);
        chk("cmp_eq", {15'd0, resp_result, resp_flags[0], resp_taken}, 32'h3);
        one(FN_CMP, COND_LT, 16'h0001, 16'h8000, 3'd2);
        chk("cmp_lt", {31'd0, resp_taken}, 32'd1);
        one(FN_SLT, COND_NONE, 16'd3, 16'd7, 3'd3);
        chk("slt", {16'd0, resp_result}, 32'd1);
        one(FN_XNOR, COND_NONE, 16'h00FF, 16'h0F0F, 3'd4);
        chk("xnor", {16'd0, resp_result}, 32'hF00F);
        one(4'd9, COND_EQ, 16'h1234, 16'h1111, 3'd6);
        chk("illegal_res", {16'd0, resp_result}, ERR ? 32'h0 : 32'h2345);
        drain();

        // stream of 8 with resp_ready cycling 1,0,0,1
        pat = 4'b1001;
        sent = 0;
        for (int k = 0; k < 60 && sent < 8; k++) begin
            cyc(1'b1, 4'(sent % 8), 2'(sent % 4), 16'(sent * 16'h1111), 16'h3333,
                3'(sent), pat[k % 4], acc);
            if (acc) sent++;
        end
        chk("stream_sent", sent, 8);
        drain();

        // reset with both stages full
        cyc(1'b1, FN_OR, COND_GT, 16'hA5A5, 16'h0F0F, 3'd7, 1'b0, acc);
        cyc(1'b1, FN_SUB, COND_LT, 16'h0002, 16'h0009, 3'd1, 1'b0, acc);
        req_valid = 1'b1;
        #1 check_now();
        #1 rst = 1'b1;
        #1 zeros("rst_mid");
        @(posedge clk);
        e++;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        idle(1'b1);

        for (int k = 0; k < 400; k++) begin
            logic [15:0] a;
            a = 16'($urandom);
            cyc(($urandom % 4) != 0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                a, ($urandom % 4 == 0) ? a : 16'($urandom), 3'($urandom), ($urandom % 10) < 7, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage issue/retire front end for the 16-bit ALU. Accepts operation requests from decode over a valid/ready handshake, translates the ISA function code into the ALU's 4-bit operation code, drives the ALU operand and operation ports from registered state, and captures the result, flags and branch-condition outcome into a response register. The response is returned to writeback/branch logic over a second valid/ready handshake, with full backpressure and one-per-cycle throughput.

## Interface
Parameters:
- W, 16, operand/result width; must equal the ALU width.
- TAG_W, 3, width of the opaque request tag echoed on the response.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_fn  in  4  function code; 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 SLT, 7 CMP; 8–15 illegal.
- req_cond  in  2  branch condition; 0 NONE, 1 EQ, 2 LT, 3 GT.
- req_a, req_b  in  W  operands.
- req_tag  in  TAG_W  opaque tag.
- alu_data1, alu_data2  out  W  ALU operands.
- alu_operation  out  4  ALU op code; 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 SLT.
- alu_result  in  W  ALU result, combinational from alu_* outputs.
- alu_zero, alu_lt, alu_gt  in  1  ALU unsigned compare flags.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_result  out  W  captured result.
- resp_flags  out  3  {gt, lt, zero}.
- resp_taken  out  1  condition outcome.
- resp_tag  out  TAG_W  echoed tag.
- resp_err  out  1  illegal function code; exists only with ALU_ISSUE_ERR_EN.

## Operation
- S1 (issue register): s1_valid, operands, decoded ALU op, cond, tag, and the illegal bit. S1 drives the alu_* ports directly.
- S2 (response register): captures alu_result, flags, taken, tag and err from S1.
- s2_free = !s2_valid || resp_ready.
- req_ready = !s1_valid || s2_free. Purely combinational; no combinational path from req_valid.
- S1 advances into S2 when s1_valid && s2_free.
- S1 loads a request when req_valid && req_ready. Otherwise s1_valid clears if S1 advanced.
- S2 holds all fields stable while resp_valid && !resp_ready.
- Function decode:
  - fn 0–6 map to the identical ALU code.
  - CMP maps to SUB; resp_result is forced to 0 and only flags and taken are meaningful.
- resp_taken:
  - NONE → 0.
  - EQ → zero.
  - LT → lt.
  - GT → gt.
- All compares are unsigned, as the ALU's are.
- When S1 is empty, alu_operation = 0 (ADD) and the operand registers hold their last values. Only s1_valid gates capture.
- Reset (asynchronous, any cycle):
  - s1_valid = 0, s2_valid = 0, so resp_valid = 0 and req_ready = 1.
  - All data registers are set to 0, so resp_result = 0, resp_flags = 0, resp_taken = 0, resp_tag = 0, resp_err = 0, alu_* = 0.
  - In-flight requests are dropped without a response.

## Timing
- Latency: a request accepted at edge N appears with resp_valid = 1 after edge N+1.
- Throughput is 1 per cycle while resp_ready stays high.
- Full pipeline (S1 and S2 valid) with resp_ready = 0: req_ready = 0 and no state changes.
- Full pipeline with resp_ready = 1: retire, advance and accept all occur on the same edge, with no bubble.
- Ordering is strictly FIFO; exactly one response is produced per accepted request.
- The ALU path is combinational within one cycle: S1 register → ALU → S2 register.

## Configuration
- ALU_ISSUE_ERR_EN defined:
  - fn 8–15 set resp_err = 1, resp_result = 0, resp_flags = 0 and resp_taken = 0.
  - alu_operation is still driven as ADD.
- ALU_ISSUE_ERR_EN undefined:
  - There is no resp_err port.
  - Illegal fn decodes as ADD and its result is returned normally, matching the ALU's default behaviour.

## Structure
- Package alu_issue_pkg holds:
  - the function code constants (FN_ADD … FN_CMP);
  - the ALU op code constants (ALUOP_ADD … ALUOP_SLT);
  - the condition code constants (COND_NONE/EQ/LT/GT).
- One combinational sub-module, alu_fn_decode, maps req_fn to {alu op, is_cmp, illegal}. It is instantiated once, on the request input, before the S1 register.

## Test plan
- Reset: assert rst mid-transfer with S1 and S2 full. Required response: resp_valid = 0 and req_ready = 1 immediately, without waiting for a clock edge; all outputs read 0.
- ADD 0xFFFF+0x0001, tag 5, resp_ready = 1. Required response: one cycle later resp_result = 0x0000, resp_flags = {gt=1, lt=0, zero=0}, resp_tag = 5.
- CMP a=0x0010, b=0x0010, cond EQ. Required response: resp_result = 0, zero = 1, resp_taken = 1. Then CMP 0x0001 vs 0x8000 with cond LT: resp_taken = 1 (unsigned compare).
- Back-to-back stream of 8 requests with resp_ready toggled 1,0,0,1,… Required response: no loss and no duplication, FIFO tag order, and response fields stable while stalled.
- SLT 3,7 → resp_result = 1; XNOR 0x00FF,0x0F0F → 0xF00F.
- fn = 9. Required response with ALU_ISSUE_ERR_EN: resp_err = 1 and resp_result = 0. Without it: the ADD result is returned.
